cbfp_block_ctrl: RTL and testbench



---
 rtl/cbfp_ctrl_pkg.sv | 24 ++
 rtl/cbfp_rd_seq.sv | 143 ++++++++++++++
 rtl/cbfp_block_ctrl.sv | 124 ++++++++++++
 tb/tb_cbfp_block_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_ctrl_pkg.sv
// Shared types, default sizing and helpers for the CBFP block sequencer.
package cbfp_ctrl_pkg;

    localparam int DFLT_BEATS_PER_BLK = 4;  // 16 lanes x 4 beats = 64 samples
    localparam int DFLT_NUM_BLKS      = 8;  // 512-sample frame
    localparam int DFLT_CALC_LAT      = 2;  // zero-count min tree settle time

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_CALC  = 2'd1,
        RD_LATCH = 2'd2,
        RD_READ  = 2'd3
    } rd_state_t;

    // Width of a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/cbfp_rd_seq.sv
// Read-side sequencer: waits for the zero-count tree, pulses the scale latch,
// then replays one buffered block in order and tracks block/frame position.
module cbfp_rd_seq
    import cbfp_ctrl_pkg::*;
#(
    parameter int BEATS_PER_BLK = DFLT_BEATS_PER_BLK,
    parameter int NUM_BLKS      = DFLT_NUM_BLKS,
    parameter int CALC_LAT      = DFLT_CALC_LAT,
    localparam int AW = cnt_width(BEATS_PER_BLK),
    localparam int BW = cnt_width(NUM_BLKS),
    localparam int CW = cnt_width(CALC_LAT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    full_in,    // bank full flags including this cycle's sets
    output logic [1:0]    bank_clr,   // bank released on this edge
    output logic          scale_en,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          valid_out,
    output logic [BW-1:0] blk_idx,
    output logic          frame_done
);

    localparam logic [AW-1:0] RD_LAST   = AW'(BEATS_PER_BLK - 1);
    localparam logic [CW-1:0] CALC_LAST = CW'(CALC_LAT - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(NUM_BLKS - 1);

    rd_state_t     state_r;
    rd_state_t     state_nx_s;
    logic [CW-1:0] calc_cnt_r;
    logic [AW-1:0] rd_addr_r;
    logic          rd_en_r;
    logic          rd_bank_r;
    logic          scale_en_r;
    logic          valid_out_r;
    logic          vo_last_r;
    logic          frame_done_r;
    logic [BW-1:0] blk_idx_r;
    logic          rd_last_s;
    logic [1:0]    bank_clr_s;

    // Next-state decode; a freshly completed block is chained straight after the last read beat.
    always_comb begin
        state_nx_s = state_r;
        rd_last_s  = (state_r == RD_READ) && (rd_addr_r == RD_LAST);
        case (state_r)
            RD_IDLE: begin
                if (|full_in) begin
                    state_nx_s = RD_CALC;
                end else begin
                    state_nx_s = RD_IDLE;
                end
            end
            RD_CALC: begin
                if (calc_cnt_r == CALC_LAST) begin
                    state_nx_s = RD_LATCH;
                end else begin
                    state_nx_s = RD_CALC;
                end
            end
            RD_LATCH: begin
                state_nx_s = RD_READ;
            end
            RD_READ: begin
                if (rd_addr_r != RD_LAST) begin
                    state_nx_s = RD_READ;
                end else if (full_in[~rd_bank_r]) begin
                    state_nx_s = RD_CALC;
                end else begin
                    state_nx_s = RD_IDLE;
                end
            end
            default: begin
                state_nx_s = RD_IDLE;
            end
        endcase
    end

    // Release the bank being read on its last read beat.
    always_comb begin
        bank_clr_s = 2'b00;
        if (rd_last_s) begin
            bank_clr_s[rd_bank_r] = 1'b1;
        end else begin
            bank_clr_s = 2'b00;
        end
    end

    // State register plus registered read-side outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_r      <= RD_IDLE;
            calc_cnt_r   <= {CW{1'b0}};
            rd_addr_r    <= {AW{1'b0}};
            rd_en_r      <= 1'b0;
            rd_bank_r    <= 1'b0;
            scale_en_r   <= 1'b0;
            valid_out_r  <= 1'b0;
            vo_last_r    <= 1'b0;
            frame_done_r <= 1'b0;
            blk_idx_r    <= {BW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (state_r == RD_CALC) begin
                calc_cnt_r <= calc_cnt_r + CW'(1);
            end else begin
                calc_cnt_r <= {CW{1'b0}};
            end
            scale_en_r <= (state_nx_s == RD_LATCH);
            rd_en_r    <= (state_nx_s == RD_READ);
            if ((state_nx_s == RD_READ) && (state_r == RD_READ)) begin
                rd_addr_r <= rd_addr_r + AW'(1);
            end else begin
                rd_addr_r <= {AW{1'b0}};
            end
            if (rd_last_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
            valid_out_r  <= rd_en_r;
            vo_last_r    <= rd_last_s;
            frame_done_r <= rd_last_s && (blk_idx_r == BLK_LAST);
            if (vo_last_r) begin
                if (blk_idx_r == BLK_LAST) begin
                    blk_idx_r <= {BW{1'b0}};
                end else begin
                    blk_idx_r <= blk_idx_r + BW'(1);
                end
            end
        end
    end

    assign bank_clr   = bank_clr_s;
    assign scale_en   = scale_en_r;
    assign rd_en      = rd_en_r;
    assign rd_bank    = rd_bank_r;
    assign rd_addr    = rd_addr_r;
    assign valid_out  = valid_out_r;
    assign blk_idx    = blk_idx_r;
    assign frame_done = frame_done_r;

endmodule

// File: rtl/cbfp_block_ctrl.sv
// CBFP block sequencer top: groups input beats into blocks, steers them into
// a ping-pong buffer, drops blocks that find their bank occupied, and hands
// completed banks to the read sequencer.
module cbfp_block_ctrl
    import cbfp_ctrl_pkg::*;
#(
    parameter int BEATS_PER_BLK = DFLT_BEATS_PER_BLK,
    parameter int NUM_BLKS      = DFLT_NUM_BLKS,
    parameter int CALC_LAT      = DFLT_CALC_LAT,
    localparam int AW = cnt_width(BEATS_PER_BLK),
    localparam int BW = cnt_width(NUM_BLKS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_in,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          blk_done,
    output logic          scale_en,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          valid_out,
    output logic [BW-1:0] blk_idx,
    output logic          frame_done,
    output logic          ovf
);

    localparam logic [AW-1:0] WR_LAST = AW'(BEATS_PER_BLK - 1);

    logic [AW-1:0] wr_cnt_r;
    logic          wr_bank_r;
    logic          drop_r;        // current block is being discarded
    logic          blk_done_r;
    logic          ovf_r;
    logic [1:0]    full_r;
    logic [1:0]    full_set_s;
    logic [1:0]    full_clr_s;
    logic [1:0]    full_in_s;
    logic          first_beat_s;
    logic          bank_busy_s;
    logic          drop_now_s;
    logic          drop_blk_s;
    logic          accept_last_s;
    logic          wr_en_s;

    // Drop decision on a block's first beat; a bank released on this same edge counts as free.
    always_comb begin
        first_beat_s = valid_in && (wr_cnt_r == {AW{1'b0}});
        bank_busy_s  = full_r[wr_bank_r] && !full_clr_s[wr_bank_r];
        drop_now_s   = first_beat_s && bank_busy_s;
        if (first_beat_s) begin
            drop_blk_s = drop_now_s;
        end else begin
            drop_blk_s = drop_r;
        end
        accept_last_s = valid_in && (wr_cnt_r == WR_LAST) && !drop_blk_s;
        full_set_s    = 2'b00;
        if (accept_last_s) begin
            full_set_s[wr_bank_r] = 1'b1;
        end else begin
            full_set_s = 2'b00;
        end
        full_in_s = full_r | full_set_s;
        wr_en_s   = valid_in && !drop_blk_s;
    end

    // Write beat counter, bank toggle, full flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_cnt_r   <= {AW{1'b0}};
            wr_bank_r  <= 1'b0;
            drop_r     <= 1'b0;
            blk_done_r <= 1'b0;
            ovf_r      <= 1'b0;
            full_r     <= 2'b00;
        end else begin
            if (valid_in) begin
                if (wr_cnt_r == WR_LAST) begin
                    wr_cnt_r <= {AW{1'b0}};
                end else begin
                    wr_cnt_r <= wr_cnt_r + AW'(1);
                end
                if (first_beat_s) begin
                    drop_r <= drop_now_s;
                end
            end
            if (accept_last_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            blk_done_r <= accept_last_s;
            if (drop_now_s) begin
                ovf_r <= 1'b1;
            end
            full_r <= (full_r & ~full_clr_s) | full_set_s;
        end
    end

    cbfp_rd_seq #(
        .BEATS_PER_BLK (BEATS_PER_BLK),
        .NUM_BLKS      (NUM_BLKS),
        .CALC_LAT      (CALC_LAT)
    ) u_rd_seq (
        .clk        (clk),
        .rstn       (rstn),
        .full_in    (full_in_s),
        .bank_clr   (full_clr_s),
        .scale_en   (scale_en),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .valid_out  (valid_out),
        .blk_idx    (blk_idx),
        .frame_done (frame_done)
    );

    assign wr_en    = wr_en_s;
    assign wr_bank  = wr_bank_r;
    assign wr_addr  = wr_cnt_r;
    assign blk_done = blk_done_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_cbfp_block_ctrl.sv
// Self-checking bench for cbfp_block_ctrl: a hand-derived vector table for a
// single block, directed corner sequences, and random traffic checked against
// a schedule-based reference model.
module tb_cbfp_block_ctrl;

    localparam int BPB  = 4;
    localparam int NB   = 8;
    localparam int CL   = 2;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rstn;
    logic       valid_in;
    logic       wr_en;
    logic       wr_bank;
    logic [1:0] wr_addr;
    logic       blk_done;
    logic       scale_en;
    logic       rd_en;
    logic       rd_bank;
    logic [1:0] rd_addr;
    logic       valid_out;
    logic [2:0] blk_idx;
    logic       frame_done;
    logic       ovf;

    always #5 clk = ~clk;

    cbfp_block_ctrl #(.BEATS_PER_BLK(BPB), .NUM_BLKS(NB), .CALC_LAT(CL)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .blk_done(blk_done),
        .scale_en(scale_en), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .valid_out(valid_out), .blk_idx(blk_idx), .frame_done(frame_done), .ovf(ovf)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: per-cycle expectation arrays filled when a block is scheduled
    bit e_blk_done [MAXC];
    bit e_scale    [MAXC];
    bit e_rd_en    [MAXC];
    bit e_vo       [MAXC];
    bit e_frame    [MAXC];
    int e_rd_addr  [MAXC];
    int m_wcnt, m_wbank, m_drop, m_ovf;
    int busy_until [2];   // last read cycle of the block held in each bank
    int last_rd;          // last read cycle of the newest scheduled block
    int nsched, nread, nvo;
    int lq[$];
    int vq[$];
    int cur_v, cur_r, m_first, m_dropnow, m_dropblk;
    int vo_cnt, fd_cnt, fdvo_cnt, bd_cnt;

    typedef struct packed {
        logic       vin;
        logic       wr_en;
        logic       wr_bank;
        logic [1:0] wr_addr;
        logic       blk_done;
        logic       scale_en;
        logic       rd_en;
        logic [1:0] rd_addr;
        logic       valid_out;
        logic [2:0] blk_idx;
    } vec_t;
    vec_t tbl [14];

    function automatic vec_t mk(int vi, int we, int wb, int wa, int bd, int se,
                                int re, int ra, int vo, int bi);
        vec_t v;
        v = {1'(vi), 1'(we), 1'(wb), 2'(wa), 1'(bd), 1'(se), 1'(re), 2'(ra), 1'(vo), 3'(bi)};
        return v;
    endfunction

    function automatic void m_reset(int from);
        for (int c = from; c < MAXC; c++) begin
            e_blk_done[c] = 1'b0; e_scale[c] = 1'b0; e_rd_en[c] = 1'b0;
            e_vo[c] = 1'b0; e_frame[c] = 1'b0; e_rd_addr[c] = 0;
        end
        m_wcnt = 0; m_wbank = 0; m_drop = 0; m_ovf = 0;
        busy_until[0] = -1; busy_until[1] = -1;
        last_rd = -10; nsched = 0; nread = 0; nvo = 0;
        lq.delete(); vq.delete();
    endfunction

    // A block completed at edge k: read starts once both the block and the reader are ready
    function automatic void schedule(int k);
        int cs, l;
        cs = (k + 1 > last_rd + 1) ? k + 1 : last_rd + 1;
        e_blk_done[k+1] = 1'b1;
        e_scale[cs+CL]  = 1'b1;
        for (int i = 0; i < BPB; i++) begin
            e_rd_en[cs+CL+1+i]   = 1'b1;
            e_rd_addr[cs+CL+1+i] = i;
            e_vo[cs+CL+2+i]      = 1'b1;
        end
        l = cs + CL + BPB;
        if (nsched % NB == NB - 1) e_frame[l+1] = 1'b1;
        nsched++;
        busy_until[m_wbank] = l;
        last_rd = l;
        lq.push_back(l);
        vq.push_back(l + 1);
        m_wbank = m_wbank ^ 1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Drive one cycle's inputs and compare every output against the model
    task automatic cyc_begin(input int v, input int r);
        logic [15:0] got_v, exp_v;
        cur_v = v; cur_r = r;
        valid_in = 1'(v);
        rstn     = 1'(r);
        @(negedge clk);
        while (lq.size() > 0 && lq[0] < cyc) begin void'(lq.pop_front()); nread++; end
        while (vq.size() > 0 && vq[0] < cyc) begin void'(vq.pop_front()); nvo++; end
        m_first   = (v != 0 && m_wcnt == 0) ? 1 : 0;
        m_dropnow = (m_first != 0 && cyc < busy_until[m_wbank]) ? 1 : 0;
        m_dropblk = (m_first != 0) ? m_dropnow : m_drop;
        got_v = {wr_en, wr_bank, wr_addr, blk_done, scale_en, rd_en, rd_bank, rd_addr,
                 valid_out, blk_idx, frame_done, ovf};
        exp_v = {1'((v != 0) && (m_dropblk == 0)), 1'(m_wbank), 2'(m_wcnt), e_blk_done[cyc],
                 e_scale[cyc], e_rd_en[cyc], 1'(nread % 2), 2'(e_rd_addr[cyc]), e_vo[cyc],
                 3'(nvo % NB), e_frame[cyc], 1'(m_ovf)};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL outputs cyc=%0d got=%b expected=%b", cyc, got_v, exp_v);
        end
        if (valid_out === 1'b1) vo_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (frame_done === 1'b1 && valid_out === 1'b1) fdvo_cnt++;
        if (blk_done === 1'b1) bd_cnt++;
    endtask

    // Advance the model across the edge, then step the clock
    task automatic cyc_end();
        if (cur_r != 0) begin
            m_reset(cyc + 1);
        end else if (cur_v != 0) begin
            if (m_first != 0) m_drop = m_dropnow;
            if (m_dropnow != 0) m_ovf = 1;
            if (m_wcnt == BPB - 1) begin
                m_wcnt = 0;
                if (m_dropblk == 0) schedule(cyc);
            end else begin
                m_wcnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC - 64) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 64);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic step(input int v, input int r);
        cyc_begin(v, r);
        cyc_end();
    endtask

    task automatic run_table();
        logic [12:0] got_t;
        for (int i = 0; i < 14; i++) begin
            cyc_begin(int'(tbl[i].vin), 0);
            got_t = {wr_en, wr_bank, wr_addr, blk_done, scale_en, rd_en, rd_addr, valid_out, blk_idx};
            total++;
            if (got_t !== tbl[i][12:0]) begin
                bad++;
                $display("FAIL table row=%0d got=%b expected=%b", i, got_t, tbl[i][12:0]);
            end
            cyc_end();
        end
    endtask

    initial begin
        // single block: last beat at row 3 -> blk_done 4, scale 6, reads 7..10, valid_out 8..11
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 0, 1, 2, 1, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 1, 3, 1, 0);
        tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);

        rstn = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset(0);

        // Single block straight out of reset (first row also checks the reset state)
        run_table();

        // Mid-block gap: wr_addr holds at 2, exactly one blk_done
        bd_cnt = 0;
        step(1, 0); step(1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc_begin(0, 0);
            check("gap_wr_addr", int'(wr_addr), 2);
            cyc_end();
        end
        step(1, 0); step(1, 0);
        for (int i = 0; i < 12; i++) step(0, 0);
        check("gap_blk_done_count", bd_cnt, 1);

        // Overflow: two full banks, third block dropped, stored blocks still replayed
        step(0, 1);
        vo_cnt = 0;
        for (int i = 0; i < 8; i++) step(1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc_begin(1, 0);
            check("drop_wr_en", int'(wr_en), 0);
            cyc_end();
        end
        for (int i = 0; i < 30; i++) step(0, 0);
        check("ovf_set", int'(ovf), 1);
        check("ovf_replay_count", vo_cnt, 8);
        for (int i = 0; i < 4; i++) step(1, 0);
        for (int i = 0; i < 12; i++) step(0, 0);
        check("ovf_sticky", int'(ovf), 1);

        // Reset during the second read beat, then nominal timing again
        step(0, 1);
        for (int i = 0; i < 4; i++) step(1, 0);
        for (int i = 0; i < 4; i++) step(0, 0);
        cyc_begin(0, 1);
        check("rst_at_rd_en", int'(rd_en), 1);
        check("rst_at_rd_addr", int'(rd_addr), 1);
        cyc_end();
        cyc_begin(0, 0);
        check("rst_outputs_zero", int'({wr_en, wr_bank, wr_addr, blk_done, scale_en, rd_en,
                                        rd_bank, rd_addr, valid_out, blk_idx, frame_done, ovf}), 0);
        check("rst_full_clear", int'(dut.full_r), 0);
        cyc_end();
        run_table();

        // Inter-block gap: 8 blocks, one frame, no drops
        step(0, 1);
        vo_cnt = 0; fd_cnt = 0; fdvo_cnt = 0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 4; i++) step(1, 0);
            for (int i = 0; i < 4; i++) step(0, 0);
        end
        for (int i = 0; i < 20; i++) step(0, 0);
        check("frame_vo_count", vo_cnt, 32);
        check("frame_done_count", fd_cnt, 1);
        check("frame_done_on_vo", fdvo_cnt, 1);
        check("frame_no_ovf", int'(ovf), 0);

        // Continuous stream of 32 beats
        step(0, 1);
        for (int i = 0; i < 32; i++) step(1, 0);
        for (int i = 0; i < 40; i++) step(0, 0);

        // Random traffic at several densities with occasional resets
        for (int p = 0; p < 4; p++) begin
            int dens;
            dens = (p == 0) ? 25 : (p == 1) ? 50 : (p == 2) ? 80 : 100;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 149) == 0) begin
                    step(0, 1);
                end else begin
                    step(($urandom_range(0, 99) < dens) ? 1 : 0, 0);
                end
            end
        end
        for (int i = 0; i < 30; i++) step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
